// File: rtl/alu_sequencer_if.sv
// Program memory fetch port of the accumulator sequencer.
// Master issues PmReq/PmAddr; slave answers with PmAck/PmData.
interface alu_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              PmReq;
  logic [ADDR_W-1:0] PmAddr;
  logic              PmAck;
  logic [15:0]       PmData;

  modport master (
    output PmReq,
    output PmAddr,
    input  PmAck,
    input  PmData
  );

  modport slave (
    input  PmReq,
    input  PmAddr,
    output PmAck,
    output PmData
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the accumulator datapath.
// Fetches 16-bit instructions and drives ALU code, operand and enables.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_LD  3'd6
`endif

module alu_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Start,
  alu_sequencer_if.master pm,
  output logic [2:0]      ALUCode,
  output logic [7:0]      R,
  output logic            A_CE,
  output logic            CY_CE,
  input  logic [7:0]      A_in,
  input  logic            CY_in,
  output logic            Busy,
  output logic            Halted,
  output logic            IllegalOp
);

  localparam logic [ADDR_W-1:0] PC0 =
    ADDR_W'(START_PC);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_ILL  = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic [3:0]        ir_op;
  logic [7:0]        ir_imm;
  logic              pm_req;
  logic              a_ce;
  logic              cy_ce;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic [2:0]        alu_code;

  logic [3:0]        f_op;
  logic              f_alu;
  logic              f_arith;
  logic              f_ill;
  logic [2:0]        f_code;
  logic              take;
  logic              unused_bits;

  assign f_op        = pm.PmData[15:12];
  assign unused_bits = ^pm.PmData[11:8];

  // Decode the incoming word so EXEC outputs are registered
  always_comb begin
    f_alu   = 1'b0;
    f_arith = 1'b0;
    f_ill   = 1'b0;
    f_code  = `ALU_LD;
    unique case (1'b1)
      f_op == OP_ADD: begin
        f_alu   = 1'b1;
        f_arith = 1'b1;
        f_code  = `ALU_ADD;
      end
      f_op == OP_SUB: begin
        f_alu   = 1'b1;
        f_arith = 1'b1;
        f_code  = `ALU_SUB;
      end
      f_op == OP_AND: begin
        f_alu  = 1'b1;
        f_code = `ALU_AND;
      end
      f_op == OP_OR: begin
        f_alu  = 1'b1;
        f_code = `ALU_OR;
      end
      f_op == OP_XOR: begin
        f_alu  = 1'b1;
        f_code = `ALU_XOR;
      end
      f_op == OP_NOT: begin
        f_alu  = 1'b1;
        f_code = `ALU_NOT;
      end
      f_op == OP_LD: begin
        f_alu  = 1'b1;
        f_code = `ALU_LD;
      end
      f_op >= OP_ILL: f_ill = 1'b1;
      default: ;
    endcase
  end

  assign take =
    (ir_op == OP_JMP) ||
    (ir_op == OP_JC && CY_in) ||
    (ir_op == OP_JZ && A_in == 8'h00);

  assign pc_next = take ? ADDR_W'(ir_imm)
                        : pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      pc       <= PC0;
      ir_op    <= 4'h0;
      ir_imm   <= 8'h00;
      pm_req   <= 1'b0;
      a_ce     <= 1'b0;
      cy_ce    <= 1'b0;
      alu_code <= `ALU_LD;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      a_ce    <= 1'b0;
      cy_ce   <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        S_IDLE, S_HALTED: begin
          if (Start) begin
            pc     <= PC0;
            state  <= S_FETCH;
            pm_req <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_FETCH: begin
          if (pm.PmAck) begin
            ir_op   <= f_op;
            ir_imm  <= pm.PmData[7:0];
            state   <= S_EXEC;
            pm_req  <= 1'b0;
            a_ce    <= f_alu;
            cy_ce   <= f_arith;
            illegal <= f_ill;
            if (f_alu) alu_code <= f_code;
          end
        end
        S_EXEC: begin
          if (ir_op == OP_HALT) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state  <= S_FETCH;
            pm_req <= 1'b1;
            pc     <= pc_next;
          end
        end
      endcase
    end
  end

  assign pm.PmReq  = pm_req;
  assign pm.PmAddr = pc;
  assign ALUCode   = alu_code;
  assign R         = ir_imm;
  assign A_CE      = a_ce;
  assign CY_CE     = cy_ce;
  assign Busy      = busy;
  assign Halted    = halted;
  assign IllegalOp = illegal;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: datapath, memory responder and ISA model.
// Directed programs plus random programs with random ack delay.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_LD  3'd6
`endif

module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset;
  logic       Start;
  logic [2:0] ALUCode;
  logic [7:0] R;
  logic       A_CE;
  logic       CY_CE;
  logic       Busy;
  logic       Halted;
  logic       IllegalOp;

  logic [7:0] acc;
  logic       cy;
  logic       pre_en;
  logic [7:0] pre_a;
  logic       pre_c;
  logic [8:0] alu_res;

  alu_sequencer_if #(.ADDR_W(8)) pm ();

  alu_sequencer #(.ADDR_W(8), .START_PC(0)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .pm        (pm),
    .ALUCode   (ALUCode),
    .R         (R),
    .A_CE      (A_CE),
    .CY_CE     (CY_CE),
    .A_in      (acc),
    .CY_in     (cy),
    .Busy      (Busy),
    .Halted    (Halted),
    .IllegalOp (IllegalOp)
  );

  // Narrow-PC instance for wrap-around
  logic        Start2;
  logic        halted2;
  logic [2:0]  unused_code2;
  logic [7:0]  unused_r2;
  logic        unused_ace2;
  logic        unused_cyce2;
  logic        unused_busy2;
  logic        unused_ill2;
  logic [15:0] mem2 [16];

  alu_sequencer_if #(.ADDR_W(4)) pm2 ();

  alu_sequencer #(.ADDR_W(4), .START_PC(15)) dut2 (
    .clk       (clk),
    .Reset     (Reset),
    .Start     (Start2),
    .pm        (pm2),
    .ALUCode   (unused_code2),
    .R         (unused_r2),
    .A_CE      (unused_ace2),
    .CY_CE     (unused_cyce2),
    .A_in      (8'h00),
    .CY_in     (1'b0),
    .Busy      (unused_busy2),
    .Halted    (halted2),
    .IllegalOp (unused_ill2)
  );

  assign pm2.PmAck  = pm2.PmReq;
  assign pm2.PmData = mem2[pm2.PmAddr];

  // Datapath: ALU, accumulator and carry register
  always_comb begin
    alu_res = {cy, acc};
    case (ALUCode)
      `ALU_ADD: alu_res = {1'b0, acc} + {1'b0, R};
      `ALU_SUB: alu_res = {1'b0, acc} - {1'b0, R};
      `ALU_AND: alu_res = {cy, acc & R};
      `ALU_OR:  alu_res = {cy, acc | R};
      `ALU_XOR: alu_res = {cy, acc ^ R};
      `ALU_NOT: alu_res = {cy, ~acc};
      `ALU_LD:  alu_res = {cy, R};
      default:  alu_res = {cy, acc};
    endcase
  end

  always @(posedge clk) begin
    if (pre_en) begin
      acc <= pre_a;
      cy  <= pre_c;
    end else begin
      if (A_CE)  acc <= alu_res[7:0];
      if (CY_CE) cy  <= alu_res[8];
    end
  end

  // Program memory with configurable ack delay
  logic [15:0] mem [256];
  int          dly = 0;
  int          wait_cnt = 0;
  logic        resp_ack = 1'b0;
  logic        ack_force;
  logic [7:0]  flog [4096];
  int          n_fetch = 0;

  assign pm.PmAck  = resp_ack | ack_force;
  assign pm.PmData = mem[pm.PmAddr];

  always @(negedge clk) begin
    if (!pm.PmReq) begin
      resp_ack <= 1'b0;
      wait_cnt <= 0;
    end else if (wait_cnt >= dly) begin
      resp_ack <= 1'b1;
      wait_cnt <= 0;
      flog[n_fetch % 4096] <= pm.PmAddr;
      n_fetch <= n_fetch + 1;
    end else begin
      resp_ack <= 1'b0;
      wait_cnt <= wait_cnt + 1;
    end
  end

  int         n_ace = 0;
  int         n_cyce = 0;
  int         n_ill = 0;
  int         n_req = 0;
  int         n_unst = 0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [3:0] flog2 [64];
  int         n2 = 0;

  always @(negedge clk) begin
    if (A_CE)      n_ace  <= n_ace + 1;
    if (CY_CE)     n_cyce <= n_cyce + 1;
    if (IllegalOp) n_ill  <= n_ill + 1;
    if (pm.PmReq)  n_req  <= n_req + 1;
    if (pm.PmReq && prev_req && pm.PmAddr != prev_addr)
      n_unst <= n_unst + 1;
    prev_req  <= pm.PmReq;
    prev_addr <= pm.PmAddr;
    if (pm2.PmReq) begin
      flog2[n2 % 64] <= pm2.PmAddr;
      n2 <= n2 + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ISA-level reference: walks the program memory instruction by instruction
  int m_q[$];
  int m_a, m_c, m_ace, m_cyce, m_ill, m_edges, m_req;

  task automatic model(input int start, input int a0,
                       input int c0, input int d);
    int pc, a, c, nxt, op, imm, s;
    bit done;
    logic [15:0] ins;
    pc = start; a = a0; c = c0; done = 0;
    m_q.delete();
    m_ace = 0; m_cyce = 0; m_ill = 0;
    m_edges = 0; m_req = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      ins = mem[pc];
      op  = int'(ins[15:12]);
      imm = int'(ins[7:0]);
      m_q.push_back(pc);
      m_edges += d + 2;
      m_req   += d + 1;
      nxt = (pc + 1) % 256;
      case (op)
        1: begin
          s = a + imm; a = s % 256; c = s / 256;
          m_ace++; m_cyce++;
        end
        2: begin
          s = a - imm; c = (s < 0) ? 1 : 0;
          a = (s + 256) % 256;
          m_ace++; m_cyce++;
        end
        3: begin a = a & imm; m_ace++; end
        4: begin a = a | imm; m_ace++; end
        5: begin a = a ^ imm; m_ace++; end
        6: begin a = 255 - a; m_ace++; end
        7: begin a = imm; m_ace++; end
        8: nxt = imm;
        9: if (c == 1) nxt = imm;
        10: if (a == 0) nxt = imm;
        11: done = 1;
        12, 13, 14, 15: m_ill++;
        default: ;
      endcase
      pc = nxt;
    end
    m_a = a;
    m_c = c;
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic preload(input int a, input int c);
    @(negedge clk);
    pre_a  = a[7:0];
    pre_c  = c[0];
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic run(input string tag, input int d);
    int b_ace, b_cyce, b_ill, b_req, b_unst, b_f, n, got_f;
    dly = d;
    model(0, int'(acc), int'(cy), d);
    b_ace = n_ace; b_cyce = n_cyce; b_ill = n_ill;
    b_req = n_req; b_unst = n_unst; b_f = n_fetch;
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    n = 0;
    while (!Halted && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, 32'(Halted), 32'd1);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_cycles"}, n, m_edges);
    chk({tag, "_acc"}, 32'(acc), m_a);
    chk({tag, "_cy"}, 32'(cy), m_c);
    chk({tag, "_ace"}, n_ace - b_ace, m_ace);
    chk({tag, "_cyce"}, n_cyce - b_cyce, m_cyce);
    chk({tag, "_ill"}, n_ill - b_ill, m_ill);
    chk({tag, "_req"}, n_req - b_req, m_req);
    chk({tag, "_stable"}, n_unst - b_unst, 0);
    got_f = n_fetch - b_f;
    chk({tag, "_nfetch"}, got_f, m_q.size());
    for (int i = 0; i < m_q.size() && i < got_f; i++)
      chk($sformatf("%s_addr%0d", tag, i),
          32'(flog[(b_f + i) % 4096]), m_q[i]);
  endtask

  initial begin
    int len, op, imm, w, b_ace, b_f, n, b2;
    Reset = 1'b1; Start = 1'b0; Start2 = 1'b0;
    ack_force = 1'b0; pre_en = 1'b0;
    pre_a = 8'h00; pre_c = 1'b0;
    fill(16'hB000);
    for (int i = 0; i < 16; i++) mem2[i] = 16'hB000;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(pm.PmReq), 32'd0);
    chk("rst_addr", 32'(pm.PmAddr), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_ill", 32'(IllegalOp), 32'd0);
    chk("rst_ace", 32'(A_CE), 32'd0);
    chk("rst_cyce", 32'(CY_CE), 32'd0);
    chk("rst_code", 32'(ALUCode), 32'(`ALU_LD));
    chk("rst_r", 32'(R), 32'd0);
    Reset = 1'b0;
    preload(0, 0);

    // LD 4, ADD 3, HALT
    fill(16'hB000);
    mem[0] = 16'h7004; mem[1] = 16'h1003; mem[2] = 16'hB000;
    run("add", 0);
    chk("add_a7", 32'(acc), 32'd7);

    // LD 250, ADD 10, JC 0x10 -> LD 1, HALT
    fill(16'hB000);
    mem[0] = 16'h70FA; mem[1] = 16'h100A; mem[2] = 16'h9010;
    mem[16] = 16'h7001; mem[17] = 16'hB000;
    run("jc", 0);
    chk("jc_a1", 32'(acc), 32'd1);
    chk("jc_cy1", 32'(cy), 32'd1);

    // JZ taken, then not taken
    fill(16'hB000);
    mem[0] = 16'h7000; mem[1] = 16'hA005; mem[2] = 16'h7009;
    run("jz_t", 0);
    chk("jz_t_a0", 32'(acc), 32'd0);
    mem[0] = 16'h7003;
    run("jz_n", 1);
    chk("jz_n_a9", 32'(acc), 32'd9);

    // AND with 3-cycle ack delay
    fill(16'hB000);
    mem[0] = 16'h300F;
    preload(8'h3C, 0);
    run("and", 3);
    chk("and_a0c", 32'(acc), 32'h0C);

    // Illegal opcode acts as NOP
    fill(16'hB000);
    mem[0] = 16'hE0AA;
    preload(8'h55, 1);
    run("ill", 0);
    chk("ill_a55", 32'(acc), 32'h55);

    // Reset mid-FETCH, late ack ignored
    fill(16'hB000);
    mem[0] = 16'h7011;
    dly = 5;
    b_ace = n_ace; b_f = n_fetch;
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(pm.PmReq), 32'd1);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    ack_force = 1'b1;
    chk("rst2_req", 32'(pm.PmReq), 32'd0);
    chk("rst2_busy", 32'(Busy), 32'd0);
    chk("rst2_halted", 32'(Halted), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst2_idle_req", 32'(pm.PmReq), 32'd0);
    chk("rst2_idle_busy", 32'(Busy), 32'd0);
    chk("rst2_noace", n_ace - b_ace, 0);
    chk("rst2_nofetch", n_fetch - b_f, 0);
    ack_force = 1'b0;
    run("restart", 0);
    chk("restart_a11", 32'(acc), 32'h11);

    // Random programs, forward jumps only
    for (int t = 0; t < 25; t++) begin
      fill(16'hB000);
      len = $urandom_range(3, 12);
      for (int i = 0; i < len - 1; i++) begin
        op  = $urandom_range(0, 15);
        w   = $urandom_range(0, 15);
        imm = $urandom_range(0, 255);
        if (op == 11) op = 0;
        if (op >= 8 && op <= 10)
          imm = $urandom_range(len - 1, i + 1);
        mem[i] = {op[3:0], w[3:0], imm[7:0]};
      end
      preload($urandom_range(0, 255), $urandom_range(0, 1));
      run($sformatf("rnd%0d", t), $urandom_range(0, 3));
    end

    // 4-bit PC wraps from 15 to 0
    mem2[15] = 16'h0000;
    mem2[0]  = 16'hB000;
    b2 = n2;
    @(negedge clk); Start2 = 1'b1;
    @(negedge clk); Start2 = 1'b0;
    n = 0;
    while (!halted2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_halted", 32'(halted2), 32'd1);
    chk("wrap_nfetch", n2 - b2, 2);
    chk("wrap_addr0", 32'(flog2[b2 % 64]), 32'd15);
    chk("wrap_addr1", 32'(flog2[(b2 + 1) % 64]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
